led_driver: RTL and testbench



---
 rtl/led_driver.sv | 147 ++++++++++++++
 tb/tb_led_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// led_driver
//   Output stage between the memory-mapped LED register and the board LED pin.
//   It shapes the latched LED bit into one of three modes: steady, blink or
//   PWM-dimmed. A 16-bit config word selects the mode, the PWM duty and the
//   blink divider, and it can be read back.
//
//   cfg[1:0]  mode: 00 steady, 01 blink, 10 PWM, 11 reserved (pin forced low)
//   cfg[3:2]  stored and read back only
//   cfg[7:4]  PWM duty (on for duty/16 of each 16-cycle frame)
//   cfg[15:8] blink divider: each ON/OFF phase lasts (div+1) ticks
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous, active-low reset
//   led_in_i   latched LED bit from the LED register
//   load_i     config write strobe (one cycle per write)
//   in_i       config write data
//   out_o      config read-back (always equals cfg)
//   led_pin_o  registered drive to the board LED
//
// Parameters
//   PRESCALE   clk cycles per tick (>= 2)

module led_driver #(
  parameter int PRESCALE = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_in_i,
  input  logic        load_i,
  input  logic [15:0] in_i,
  output logic [15:0] out_o,
  output logic        led_pin_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_STEADY = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_e;

  logic [15:0]   cfg_q, cfg_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tick_cnt_q, tick_cnt_d;
  logic [3:0]    phase_q, phase_d;
  logic          led_hist_q;
  logic          led_pin_q, led_pin_d;
  blink_e        blink_q, blink_d;

  mode_e         mode;
  logic [3:0]    duty;
  logic [7:0]    div;
  logic          tick;
  logic          restart;

  assign mode = mode_e'(cfg_q[1:0]);
  assign duty = cfg_q[7:4];
  assign div  = cfg_q[15:8];

  // A config write or a rising edge on the LED bit restarts blink timing so
  // every ON phase begins cleanly; only a write realigns the PWM frame.
  assign restart = load_i | (led_in_i & ~led_hist_q);
  assign tick    = (presc_q == PMAX);

  // Timing counters and config register: next state
  always_comb begin
    cfg_d      = load_i ? in_i : cfg_q;
    phase_d    = load_i ? 4'd0 : phase_q + 4'd1;
    presc_d    = presc_q + PW'(1);
    tick_cnt_d = tick_cnt_q;
    if (restart || tick) begin
      presc_d = '0;
    end
    if (restart) begin
      tick_cnt_d = 8'd0;
    end else if (tick) begin
      tick_cnt_d = (tick_cnt_q == div) ? 8'd0 : tick_cnt_q + 8'd1;
    end
  end

  // Blink FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_q <= BLINK_ON;
    end else begin
      blink_q <= blink_d;
    end
  end

  // Blink FSM: next state
  always_comb begin
    blink_d = blink_q;
    if (restart) begin
      blink_d = BLINK_ON;
    end else if (tick && (tick_cnt_q == div)) begin
      case (blink_q)
        BLINK_ON:  blink_d = BLINK_OFF;
        BLINK_OFF: blink_d = BLINK_ON;
        default:   blink_d = BLINK_ON;
      endcase
    end
  end

  // Pin drive: uses the current cfg and timing state, so a write only shows
  // on the pin one edge after it is captured.
  always_comb begin
    led_pin_d = 1'b0;
    case (mode)
      MODE_STEADY: led_pin_d = led_in_i;
      MODE_BLINK:  led_pin_d = led_in_i & (blink_q == BLINK_ON);
      MODE_PWM:    led_pin_d = led_in_i & (phase_q < duty);
      default:     led_pin_d = 1'b0;
    endcase
  end

  // Registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q      <= 16'h0000;
      presc_q    <= '0;
      tick_cnt_q <= 8'd0;
      phase_q    <= 4'd0;
      led_hist_q <= 1'b0;
      led_pin_q  <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      led_hist_q <= led_in_i;
      led_pin_q  <= led_pin_d;
    end
  end

  assign out_o     = cfg_q;
  assign led_pin_o = led_pin_q;

endmodule

// File: tb/tb_led_driver.sv
module tb_led_driver;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        led_in = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        led_pin;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        pin;
    logic [15:0] out;
  } exp_t;

  exp_t sbq[$];

  // Reference model state: config, cycles since last timing restart,
  // cycles since last write, previous LED bit.
  logic [15:0] m_cfg = 16'h0000;
  int          m_eb  = 0;
  int          m_ep  = 0;
  logic        m_hist = 1'b0;

  led_driver #(.PRESCALE(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_in_i  (led_in),
    .load_i    (load),
    .in_i      (din),
    .out_o     (dout),
    .led_pin_o (led_pin)
  );

  always #5 clk = ~clk;

  // Pin value from elapsed time: each blink phase is (div+1)*P cycles long,
  // PWM is on while the 16-cycle frame position is below duty.
  function automatic logic model_pin(input logic [15:0] c, input int eb,
                                     input int ep, input logic li);
    int d;
    d = int'(c[15:8]) + 1;
    case (c[1:0])
      2'b00:   return li;
      2'b01:   return li && (((eb / P) / d) % 2 == 0);
      2'b10:   return li && ((ep % 16) < int'(c[7:4]));
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic ld, input logic [15:0] d,
                     input logic li);
    exp_t e;
    logic rs;
    @(negedge clk);
    rst_n  = r;
    load   = ld;
    din    = d;
    led_in = li;
    if (!r) begin
      m_cfg  = 16'h0000;
      m_eb   = 0;
      m_ep   = 0;
      m_hist = 1'b0;
      e.pin  = 1'b0;
    end else begin
      e.pin  = model_pin(m_cfg, m_eb, m_ep, li);
      rs     = ld || (li && !m_hist);
      if (ld) m_cfg = d;
      m_eb   = rs ? 0 : m_eb + 1;
      m_ep   = ld ? 0 : m_ep + 1;
      m_hist = li;
    end
    e.out = m_cfg;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n, input logic li);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0000, li);
  endtask

  task automatic wr(input logic [15:0] d, input logic li);
    cyc(1'b1, 1'b1, d, li);
  endtask

  // Monitor: one expected entry per active edge, checked 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        tests++;
        if (led_pin !== e.pin) begin
          fails++;
          $display("FAIL led_pin t=%0t got %b want %b", $time, led_pin, e.pin);
        end
        tests++;
        if (dout !== e.out) begin
          fails++;
          $display("FAIL out t=%0t got %h want %h", $time, dout, e.out);
        end
      end
    end
  end

  initial begin
    logic        r, ld, li;
    logic [15:0] d;
    int          wait_cnt;

    // Reset held with a write pending: reset must win
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'hFFFF, 1'b1);
    idle(3, 1'b0);

    // Steady mode: pin follows led_in with one cycle of lag
    wr(16'h0000, 1'b0);
    idle(5, 1'b1);
    idle(5, 1'b0);
    idle(5, 1'b1);
    idle(3, 1'b0);

    // Blink, div=1: 8 on, 8 off, 8 on
    wr(16'h0101, 1'b1);
    idle(26, 1'b1);

    // PWM duty 4, duty 0, duty 15
    wr(16'h0042, 1'b1);
    idle(40, 1'b1);
    wr(16'h0002, 1'b1);
    idle(20, 1'b1);
    wr(16'h00F2, 1'b1);
    idle(34, 1'b1);

    // Blink div=0, drop led_in mid-OFF and raise it 3 cycles later
    wr(16'h0001, 1'b1);
    idle(6, 1'b1);
    idle(3, 1'b0);
    idle(12, 1'b1);

    // Reserved mode: pin low whatever led_in does
    wr(16'h0003, 1'b1);
    idle(4, 1'b1);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Reset mid-blink ON phase, then steady behaviour
    wr(16'h0101, 1'b1);
    idle(3, 1'b1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(4, 1'b1);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Write coinciding with led_in rise, then back-to-back writes
    idle(2, 1'b0);
    wr(16'h0001, 1'b1);
    idle(5, 1'b1);
    wr(16'h0042, 1'b1);
    wr(16'h0201, 1'b1);
    idle(30, 1'b1);

    // Randomized traffic
    li = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) != 0);
      ld = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 14) == 0) li = ~li;
      d  = 16'($urandom);
      d[15:8] = 8'($urandom_range(0, 3));
      cyc(r, ld, d, li);
    end

    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
